// File: rtl/nodf_mon_pkg.sv
// Shared constants, the cycle-count type and the modular difference helper for
// the non-dataflow block-handshake monitor.
package nodf_mon_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 4;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Elapsed cycles from b to a; wraps naturally modulo 2^CNT_W_DEF.
  function automatic cnt_t cyc_diff(input cnt_t a, input cnt_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/nodf_module_if_if.sv
// Block-level HLS handshake bundle (ap_start/ap_ready/ap_done/ap_continue) plus
// the end-of-run strobe, as seen by the monitored module and its monitor.
interface nodf_hs_if;

  // Handshake semantics: a start is accepted while ap_start is high and ends
  // on an ap_ready cycle; a done completes on any cycle with ap_done & ap_continue.
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;
  logic finish;

  modport master (
    output ap_start,
    output ap_ready,
    output ap_done,
    output ap_continue,
    output finish
  );

  modport slave (
    input ap_start,
    input ap_ready,
    input ap_done,
    input ap_continue,
    input finish
  );

endinterface

// File: rtl/nodf_ts_fifo.sv
// Start-timestamp FIFO for the handshake monitor; a push and a pop may share a
// cycle even when full, the popped slot being reused by the new entry.
module nodf_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nodf_module_if.sv
// Passive status monitor for one non-dataflow HLS block handshake: event counts,
// start-to-done latency and start-to-start interval. Optional NODF_MINMAX_EN adds min/max latency.
module nodf_module_if
  import nodf_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  nodf_hs_if.slave         hs,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] ready_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] last_interval,
`ifdef NODF_MINMAX_EN
  output logic [CNT_W-1:0] min_latency,
  output logic [CNT_W-1:0] max_latency,
`endif
  output logic             busy,
  output logic             finished,
  output logic             ovf,
  output logic             unf
);

  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] prev_ts;
  logic [CNT_W-1:0] head;
  logic [CNT_W-1:0] lat_now;
  logic [CNT_W-1:0] int_now;
  logic             in_input;
  logic             have_prev;
  logic             full;
  logic             empty;
  logic             active;
  logic             start_evt;
  logic             done_evt;
  logic             bypass;
  logic             pop;
  logic             push;

  assign active    = ~finished;
  assign start_evt = hs.ap_start & ~in_input;
  assign done_evt  = hs.ap_done & hs.ap_continue;

  // A done meeting an empty FIFO in the same cycle as a start pairs with it directly.
  assign bypass = start_evt & done_evt & empty;
  assign pop    = active & done_evt & ~empty;
  assign push   = active & start_evt & ~bypass & (~full | pop);

  assign lat_now = CNT_W'(cyc_diff(cnt_t'(timer), cnt_t'(head)));
  assign int_now = CNT_W'(cyc_diff(cnt_t'(timer), cnt_t'(prev_ts)));

  assign busy = ~empty;

  nodf_ts_fifo #(
    .DEPTH (DEPTH),
    .W     (CNT_W)
  ) u_ts_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (timer),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer         <= '0;
      prev_ts       <= '0;
      have_prev     <= 1'b0;
      in_input      <= 1'b0;
      start_cnt     <= '0;
      ready_cnt     <= '0;
      done_cnt      <= '0;
      last_latency  <= '0;
      last_interval <= '0;
      finished      <= 1'b0;
      ovf           <= 1'b0;
      unf           <= 1'b0;
    end else if (active) begin
      timer <= timer + 1'b1;
      if (hs.finish) finished <= 1'b1;

      if (hs.ap_ready)     in_input <= 1'b0;
      else if (start_evt)  in_input <= 1'b1;

      if (hs.ap_ready) ready_cnt <= ready_cnt + 1'b1;

      if (start_evt) begin
        start_cnt <= start_cnt + 1'b1;
        prev_ts   <= timer;
        have_prev <= 1'b1;
        if (have_prev) last_interval <= int_now;
        if (full && !pop) ovf <= 1'b1;
      end

      if (done_evt) begin
        done_cnt <= done_cnt + 1'b1;
        if (pop)               last_latency <= lat_now;
        else if (bypass)       last_latency <= '0;
        else                   unf <= 1'b1;
      end
    end
  end

`ifdef NODF_MINMAX_EN
  logic             lat_valid;
  logic [CNT_W-1:0] lat_val;

  assign lat_valid = pop | (active & bypass);
  assign lat_val   = pop ? lat_now : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_latency <= '1;
      max_latency <= '0;
    end else if (lat_valid) begin
      if (lat_val < min_latency) min_latency <= lat_val;
      if (lat_val > max_latency) max_latency <= lat_val;
    end
  end
`endif

endmodule

// File: tb/tb_nodf_module_if.sv
// Self-checking bench for nodf_module_if: directed test-plan scenarios plus a
// randomized run against a queue-based reference model.
module tb_nodf_module_if;

  localparam int W = 32;
  localparam int D = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  nodf_hs_if hs ();

  logic [W-1:0] start_cnt, ready_cnt, done_cnt, last_latency, last_interval;
`ifdef NODF_MINMAX_EN
  logic [W-1:0] min_latency, max_latency;
`endif
  logic busy, finished, ovf, unf;

  nodf_module_if #(.CNT_W(W), .DEPTH(D)) dut (
    .clock         (clock),
    .reset         (reset),
    .hs            (hs),
    .start_cnt     (start_cnt),
    .ready_cnt     (ready_cnt),
    .done_cnt      (done_cnt),
    .last_latency  (last_latency),
    .last_interval (last_interval),
`ifdef NODF_MINMAX_EN
    .min_latency   (min_latency),
    .max_latency   (max_latency),
`endif
    .busy          (busy),
    .finished      (finished),
    .ovf           (ovf),
    .unf           (unf)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, derived from the event rules
  logic [W-1:0] m_timer, m_prev, m_start, m_ready, m_done, m_lat, m_int, m_min, m_max;
  bit           m_have_prev, m_in_input, m_fin, m_ovf, m_unf;
  logic [W-1:0] m_q[$];

  task automatic model_clear();
    m_timer = 0; m_prev = 0; m_start = 0; m_ready = 0; m_done = 0;
    m_lat = 0; m_int = 0; m_min = '1; m_max = 0;
    m_have_prev = 0; m_in_input = 0; m_fin = 0; m_ovf = 0; m_unf = 0;
    m_q.delete();
  endtask

  task automatic model_lat(input logic [W-1:0] l);
    m_lat = l;
    if (l < m_min) m_min = l;
    if (l > m_max) m_max = l;
  endtask

  task automatic model_update();
    bit se, de;
    if (m_fin) return;
    se = hs.ap_start && !m_in_input;
    de = hs.ap_done && hs.ap_continue;
    if (hs.ap_ready) m_ready++;
    if (se) begin
      m_start++;
      if (m_have_prev) m_int = m_timer - m_prev;
      m_prev = m_timer;
      m_have_prev = 1;
    end
    if (de) begin
      m_done++;
      if (m_q.size() > 0) begin
        model_lat(m_timer - m_q.pop_front());
        if (se) m_q.push_back(m_timer);
      end else if (se) begin
        model_lat(0);
      end else begin
        m_unf = 1;
      end
    end else if (se) begin
      if (m_q.size() < D) m_q.push_back(m_timer);
      else m_ovf = 1;
    end
    if (hs.ap_ready) m_in_input = 0;
    else if (se) m_in_input = 1;
    if (hs.finish) m_fin = 1;
    m_timer++;
  endtask

  task automatic drive(input bit s, input bit r, input bit d, input bit c, input bit f);
    hs.ap_start = s; hs.ap_ready = r; hs.ap_done = d; hs.ap_continue = c; hs.finish = f;
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({start_cnt, ready_cnt, done_cnt, last_latency, last_interval} !== '0 ||
        {busy, finished, ovf, unf} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs got start=%0d ready=%0d done=%0d lat=%0d int=%0d flags=%b exp all zero",
               start_cnt, ready_cnt, done_cnt, last_latency, last_interval, {busy, finished, ovf, unf});
    end
`ifdef NODF_MINMAX_EN
    checks++;
    if (min_latency !== '1 || max_latency !== '0) begin
      failures++;
      $display("FAIL reset_minmax got min=%h max=%h exp ffffffff/0", min_latency, max_latency);
    end
`endif
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(c == 2, c == 2, c == 7, 1, 0);
      tick();
      checks++;
      if (busy !== (c >= 2 && c <= 6)) begin
        failures++;
        $display("FAIL single_busy cycle=%0d got=%0b exp=%0b", c + 1, busy, (c >= 2 && c <= 6));
      end
    end
    checks++;
    if (start_cnt !== 1 || ready_cnt !== 1 || done_cnt !== 1) begin
      failures++;
      $display("FAIL single_counts got start=%0d ready=%0d done=%0d exp 1/1/1", start_cnt, ready_cnt, done_cnt);
    end
    checks++;
    if (last_latency !== 5) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=5", last_latency);
    end
  endtask

  task automatic test_pipelined();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      bit s;
      s = (c == 2 || c == 5 || c == 8);
      drive(s, s, (c == 10 || c == 13 || c == 16), 1, 0);
      tick();
      if (c == 5 || c == 8) begin
        checks++;
        if (last_interval !== 3) begin
          failures++;
          $display("FAIL pipe_interval cycle=%0d got=%0d exp=3", c, last_interval);
        end
      end
      if (c == 10 || c == 13 || c == 16) begin
        checks++;
        if (last_latency !== 8) begin
          failures++;
          $display("FAIL pipe_latency cycle=%0d got=%0d exp=8", c, last_latency);
        end
      end
    end
    checks++;
    if (ovf !== 1'b0 || done_cnt !== 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pipe_final got ovf=%0b done=%0d busy=%0b exp 0/3/0", ovf, done_cnt, busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(c[0], c[0], 0, 1, 0);
      tick();
      if (c == 7) begin
        checks++;
        if (ovf !== 1'b0) begin
          failures++;
          $display("FAIL ovf_early got=%0b exp=0", ovf);
        end
      end
    end
    checks++;
    if (start_cnt !== 5 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got start=%0d ovf=%0b exp 5/1", start_cnt, ovf);
    end
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, c[0], 1, 0);
      tick();
      if (c == 7) begin
        checks++;
        if (unf !== 1'b0 || last_latency !== m_lat) begin
          failures++;
          $display("FAIL unf_early got unf=%0b lat=%0d exp 0/%0d", unf, last_latency, m_lat);
        end
      end
    end
    checks++;
    if (done_cnt !== 5 || unf !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL unf_set got done=%0d unf=%0b busy=%0b exp 5/1/0", done_cnt, unf, busy);
    end
  endtask

  task automatic test_held_start();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(c >= 1 && c <= 6, c == 4, c >= 7 && c <= 9, c == 9, 0);
      tick();
      if (c == 8) begin
        checks++;
        if (done_cnt !== 0) begin
          failures++;
          $display("FAIL held_gated_done got=%0d exp=0", done_cnt);
        end
      end
    end
    checks++;
    if (start_cnt !== 2 || done_cnt !== 1 || ready_cnt !== 1) begin
      failures++;
      $display("FAIL held_counts got start=%0d done=%0d ready=%0d exp 2/1/1", start_cnt, done_cnt, ready_cnt);
    end
    checks++;
    if (last_latency !== 8 || last_interval !== 4) begin
      failures++;
      $display("FAIL held_timing got lat=%0d int=%0d exp 8/4", last_latency, last_interval);
    end
  endtask

  task automatic test_finish();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      drive(c == 2, c == 2, c == 25, 1, c == 20);
      tick();
      if (c == 20) begin
        checks++;
        if (finished !== 1'b1) begin
          failures++;
          $display("FAIL finish_set got=%0b exp=1", finished);
        end
      end
    end
    checks++;
    if (done_cnt !== 0 || last_latency !== 0 || start_cnt !== 1 || busy !== 1'b1 || unf !== 1'b0) begin
      failures++;
      $display("FAIL finish_frozen got done=%0d lat=%0d start=%0d busy=%0b unf=%0b exp 0/0/1/1/0",
               done_cnt, last_latency, start_cnt, busy, unf);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (start_cnt !== 0 || ready_cnt !== 0 || finished !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL finish_async_reset got start=%0d ready=%0d fin=%0b busy=%0b exp all 0",
               start_cnt, ready_cnt, finished, busy);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_bypass();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(c == 3, c == 3, c == 3, 1, 0);
      tick();
    end
    checks++;
    if (last_latency !== 0 || unf !== 1'b0 || busy !== 1'b0 || start_cnt !== 1 || done_cnt !== 1) begin
      failures++;
      $display("FAIL bypass got lat=%0d unf=%0b busy=%0b start=%0d done=%0d exp 0/0/0/1/1",
               last_latency, unf, busy, start_cnt, done_cnt);
    end
`ifdef NODF_MINMAX_EN
    checks++;
    if (min_latency !== 0 || max_latency !== 0) begin
      failures++;
      $display("FAIL bypass_minmax got min=%0d max=%0d exp 0/0", min_latency, max_latency);
    end
`endif
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 4, $urandom_range(0, 1), $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) < 7, c == 580);
      tick();
      checks++;
      if (start_cnt !== m_start || ready_cnt !== m_ready || done_cnt !== m_done ||
          last_latency !== m_lat || last_interval !== m_int || busy !== (m_q.size() != 0) ||
          ovf !== m_ovf || unf !== m_unf || finished !== m_fin) begin
        failures++;
        errs++;
        if (errs <= 5)
          $display("FAIL random cycle=%0d got s=%0d r=%0d d=%0d lat=%0d int=%0d b=%0b o=%0b u=%0b f=%0b exp s=%0d r=%0d d=%0d lat=%0d int=%0d b=%0b o=%0b u=%0b f=%0b",
                   c, start_cnt, ready_cnt, done_cnt, last_latency, last_interval, busy, ovf, unf, finished,
                   m_start, m_ready, m_done, m_lat, m_int, m_q.size() != 0, m_ovf, m_unf, m_fin);
      end
`ifdef NODF_MINMAX_EN
      checks++;
      if (min_latency !== m_min || max_latency !== m_max) begin
        failures++;
        errs++;
        if (errs <= 5)
          $display("FAIL random_minmax cycle=%0d got min=%0d max=%0d exp min=%0d max=%0d",
                   c, min_latency, max_latency, m_min, m_max);
      end
`endif
    end
  endtask

  initial begin
    drive(0, 0, 0, 1, 0);
    reset = 1'b1;
    model_clear();
    test_reset();
    test_single();
    test_pipelined();
    test_overflow();
    test_held_start();
    test_finish();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
